// File: rtl/display_hdmi_pkg.sv
// Shared constants and types for the HDMI YCbCr 4:2:2 -> RGB receive path.
package display_hdmi_pkg;

    // Width of the signed accumulator used for the colour matrix sums.
    localparam int SUM_W = 22;
    // Width of the offset-removed signed Y/Cb/Cr components.
    localparam int COMP_W = 9;

    // BT.601 limited-range coefficients scaled by 2^10.
    localparam logic signed [SUM_W-1:0] K_Y    = 22'sd1192;
    localparam logic signed [SUM_W-1:0] K_R_CR = 22'sd1634;
    localparam logic signed [SUM_W-1:0] K_G_CB = 22'sd401;
    localparam logic signed [SUM_W-1:0] K_G_CR = 22'sd832;
    localparam logic signed [SUM_W-1:0] K_B_CB = 22'sd2066;

    // One 16-bit 4:2:2 sample as it arrives on the HDMI side.
    typedef struct packed {
        logic [7:0] c;
        logic [7:0] y;
    } yuv422_pix_t;

    // Clamp a signed matrix result into the 8-bit colour range.
    function automatic logic [7:0] sat_u8(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1]) begin
            return 8'd0;
        end
        if (v > SUM_W'(255)) begin
            return 8'd255;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/display_hdmi_yuv2rgb_matrix.sv
// Three-stage YCbCr -> RGB colour matrix: multiply, sum with rounding, shift and clamp.
// A sideband bus travels with the valid so syncs stay aligned to the pixels.
module display_hdmi_yuv2rgb_matrix
    import display_hdmi_pkg::*;
#(
    parameter int COEF_FRAC = 10,
    parameter int SB_W      = 2
) (
    input  logic                     iHdmiClk,
    input  logic                     iArst,
    input  logic                     in_valid,
    input  logic [SB_W-1:0]          in_sb,
    input  logic signed [COMP_W-1:0] y_in,
    input  logic signed [COMP_W-1:0] cb_in,
    input  logic signed [COMP_W-1:0] cr_in,
    output logic                     out_valid,
    output logic [SB_W-1:0]          out_sb,
    output logic [7:0]               red,
    output logic [7:0]               green,
    output logic [7:0]               blue
);

    localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1) <<< (COEF_FRAC - 1);

    logic signed [SUM_W-1:0] y_ext;
    logic signed [SUM_W-1:0] cb_ext;
    logic signed [SUM_W-1:0] cr_ext;

    assign y_ext  = SUM_W'(y_in);
    assign cb_ext = SUM_W'(cb_in);
    assign cr_ext = SUM_W'(cr_in);

    logic                    valid_s2_reg;
    logic [SB_W-1:0]         sb_s2_reg;
    logic signed [SUM_W-1:0] py_reg;
    logic signed [SUM_W-1:0] p_r_cr_reg;
    logic signed [SUM_W-1:0] p_g_cb_reg;
    logic signed [SUM_W-1:0] p_g_cr_reg;
    logic signed [SUM_W-1:0] p_b_cb_reg;

    logic                    valid_s3_reg;
    logic [SB_W-1:0]         sb_s3_reg;
    logic signed [SUM_W-1:0] sum_s3_reg [3];

    logic                    valid_s4_reg;
    logic [SB_W-1:0]         sb_s4_reg;
    logic [7:0]              rgb_s4_reg [3];
    logic [7:0]              sat_s4 [3];

    // S2: all coefficient products in parallel.
    always_ff @(posedge iHdmiClk or posedge iArst) begin
        if (iArst) begin
            valid_s2_reg <= 1'b0;
            sb_s2_reg    <= '0;
            py_reg       <= '0;
            p_r_cr_reg   <= '0;
            p_g_cb_reg   <= '0;
            p_g_cr_reg   <= '0;
            p_b_cb_reg   <= '0;
        end else begin
            valid_s2_reg <= in_valid;
            sb_s2_reg    <= in_sb;
            py_reg       <= y_ext  * K_Y;
            p_r_cr_reg   <= cr_ext * K_R_CR;
            p_g_cb_reg   <= cb_ext * K_G_CB;
            p_g_cr_reg   <= cr_ext * K_G_CR;
            p_b_cb_reg   <= cb_ext * K_B_CB;
        end
    end

    // S3: per-channel sums with half-LSB rounding folded in.
    always_ff @(posedge iHdmiClk or posedge iArst) begin
        if (iArst) begin
            valid_s3_reg <= 1'b0;
            sb_s3_reg    <= '0;
            for (int i = 0; i < 3; i++) begin
                sum_s3_reg[i] <= '0;
            end
        end else begin
            valid_s3_reg  <= valid_s2_reg;
            sb_s3_reg     <= sb_s2_reg;
            sum_s3_reg[0] <= py_reg + p_r_cr_reg + ROUND;
            sum_s3_reg[1] <= py_reg - p_g_cb_reg - p_g_cr_reg + ROUND;
            sum_s3_reg[2] <= py_reg + p_b_cb_reg + ROUND;
        end
    end

    // S4 combinational part: drop the fraction and clamp each channel.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sat
        logic signed [SUM_W-1:0] shifted;
        assign shifted    = sum_s3_reg[gi] >>> COEF_FRAC;
        assign sat_s4[gi] = sat_u8(shifted);
    end

    // S4 register: blank colour outside the active region.
    always_ff @(posedge iHdmiClk or posedge iArst) begin
        if (iArst) begin
            valid_s4_reg <= 1'b0;
            sb_s4_reg    <= '0;
            for (int i = 0; i < 3; i++) begin
                rgb_s4_reg[i] <= '0;
            end
        end else begin
            valid_s4_reg <= valid_s3_reg;
            sb_s4_reg    <= sb_s3_reg;
            for (int i = 0; i < 3; i++) begin
                rgb_s4_reg[i] <= valid_s3_reg ? sat_s4[i] : 8'd0;
            end
        end
    end

    assign out_valid = valid_s4_reg;
    assign out_sb    = sb_s4_reg;
    assign red       = rgb_s4_reg[0];
    assign green     = rgb_s4_reg[1];
    assign blue      = rgb_s4_reg[2];

endmodule

// File: rtl/display_hdmi_yuv422_to_rgb.sv
// HDMI YCbCr 4:2:2 -> 24-bit RGB with active-high syncs, fixed 5-cycle latency.
// Owns sync normalisation, chroma pairing, frame counting and odd-line detection.
module display_hdmi_yuv422_to_rgb
    import display_hdmi_pkg::*;
#(
    parameter logic [7:0] Y_OFFSET    = 8'd16,
    parameter logic [7:0] C_OFFSET    = 8'd128,
    parameter int         COEF_FRAC   = 10,
    parameter logic       SYNC_IN_LOW = 1'b1
) (
    input  logic        iHdmiClk,
    input  logic        iArst,
    input  logic        iHdmiYuvVs,
    input  logic        iHdmiYuvHs,
    input  logic        iHdmiYuvDe,
    input  logic [15:0] iv16HdmiYuvData,
    output logic [7:0]  ov8Red,
    output logic [7:0]  ov8Green,
    output logic [7:0]  ov8Blue,
    output logic        oRgbVd,
    output logic        oRgbVs,
    output logic        oRgbHs,
    output logic [11:0] ov12FrameCnt,
    output logic        oOddLine
);

    logic vs_norm;
    logic hs_norm;

    assign vs_norm = SYNC_IN_LOW ? ~iHdmiYuvVs : iHdmiYuvVs;
    assign hs_norm = SYNC_IN_LOW ? ~iHdmiYuvHs : iHdmiYuvHs;

    // S0 state: phase_reg is the phase the next De-high sample will take.
    yuv422_pix_t s0_pix_reg;
    logic        s0_de_reg;
    logic        s0_vs_reg;
    logic        s0_hs_reg;
    logic        s0_odd_reg;
    logic        phase_reg;

    // S1 state: Y (and its own chroma byte) delayed one cycle so the
    // following sample's Cr is visible when an even pixel is converted.
    yuv422_pix_t s1_pix_reg;
    logic        s1_de_reg;
    logic        s1_vs_reg;
    logic        s1_hs_reg;
    logic        s1_odd_reg;
    logic [7:0]  cb_hold_reg;

    logic [11:0] frame_cnt_reg;
    logic        odd_line_reg;

    logic [7:0]  cb_sel;
    logic [7:0]  cr_sel;
    logic        line_ends_odd;

    logic signed [COMP_W-1:0] y_c;
    logic signed [COMP_W-1:0] cb_c;
    logic signed [COMP_W-1:0] cr_c;

    // S0: capture inputs, normalise syncs, tag each active pixel with its phase.
    always_ff @(posedge iHdmiClk or posedge iArst) begin
        if (iArst) begin
            s0_pix_reg <= '0;
            s0_de_reg  <= 1'b0;
            s0_vs_reg  <= 1'b0;
            s0_hs_reg  <= 1'b0;
            s0_odd_reg <= 1'b0;
            phase_reg  <= 1'b0;
        end else begin
            s0_pix_reg <= yuv422_pix_t'(iv16HdmiYuvData);
            s0_de_reg  <= iHdmiYuvDe;
            s0_vs_reg  <= vs_norm;
            s0_hs_reg  <= hs_norm;
            if (iHdmiYuvDe) begin
                s0_odd_reg <= phase_reg;
                phase_reg  <= ~phase_reg;
            end else begin
                s0_odd_reg <= 1'b0;
                phase_reg  <= 1'b0;
            end
        end
    end

    // S1: one-cycle delay of the pixel plus the Cb hold for the odd partner.
    always_ff @(posedge iHdmiClk or posedge iArst) begin
        if (iArst) begin
            s1_pix_reg  <= '0;
            s1_de_reg   <= 1'b0;
            s1_vs_reg   <= 1'b0;
            s1_hs_reg   <= 1'b0;
            s1_odd_reg  <= 1'b0;
            cb_hold_reg <= '0;
        end else begin
            s1_pix_reg <= s0_pix_reg;
            s1_de_reg  <= s0_de_reg;
            s1_vs_reg  <= s0_vs_reg;
            s1_hs_reg  <= s0_hs_reg;
            s1_odd_reg <= s0_odd_reg;
            if (s1_de_reg && !s1_odd_reg) begin
                cb_hold_reg <= s1_pix_reg.c;
            end
        end
    end

    // Chroma pairing: even pixel takes its own Cb and the next sample's Cr;
    // odd pixel reuses the held Cb and its own Cr. An even pixel with no
    // successor ends an odd-length line and gets neutral Cr.
    always_comb begin
        cb_sel        = s1_pix_reg.c;
        cr_sel        = C_OFFSET;
        line_ends_odd = 1'b0;
        if (s1_odd_reg) begin
            cb_sel = cb_hold_reg;
            cr_sel = s1_pix_reg.c;
        end else if (s0_de_reg) begin
            cr_sel = s0_pix_reg.c;
        end else begin
            line_ends_odd = s1_de_reg;
        end
    end

    assign y_c  = $signed({1'b0, s1_pix_reg.y} - {1'b0, Y_OFFSET});
    assign cb_c = $signed({1'b0, cb_sel} - {1'b0, C_OFFSET});
    assign cr_c = $signed({1'b0, cr_sel} - {1'b0, C_OFFSET});

    // Frame counter on the normalised Vs rising edge; sticky odd-line flag.
    always_ff @(posedge iHdmiClk or posedge iArst) begin
        if (iArst) begin
            frame_cnt_reg <= '0;
            odd_line_reg  <= 1'b0;
        end else begin
            if (vs_norm && !s0_vs_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 12'd1;
            end
            if (line_ends_odd) begin
                odd_line_reg <= 1'b1;
            end
        end
    end

    logic [1:0] sync_out;

    display_hdmi_yuv2rgb_matrix #(
        .COEF_FRAC (COEF_FRAC),
        .SB_W      (2)
    ) u_matrix (
        .iHdmiClk  (iHdmiClk),
        .iArst     (iArst),
        .in_valid  (s1_de_reg),
        .in_sb     ({s1_vs_reg, s1_hs_reg}),
        .y_in      (y_c),
        .cb_in     (cb_c),
        .cr_in     (cr_c),
        .out_valid (oRgbVd),
        .out_sb    (sync_out),
        .red       (ov8Red),
        .green     (ov8Green),
        .blue      (ov8Blue)
    );

    assign oRgbVs       = sync_out[1];
    assign oRgbHs       = sync_out[0];
    assign ov12FrameCnt = frame_cnt_reg;
    assign oOddLine     = odd_line_reg;

endmodule

// File: tb/tb_display_hdmi_yuv422_to_rgb.sv
// Directed bench for the HDMI YCbCr 4:2:2 -> RGB converter.
module tb_display_hdmi_yuv422_to_rgb;

    logic        iHdmiClk = 1'b0;
    logic        iArst = 1'b1;
    logic        iHdmiYuvVs = 1'b1;
    logic        iHdmiYuvHs = 1'b1;
    logic        iHdmiYuvDe = 1'b0;
    logic [15:0] iv16HdmiYuvData = 16'h0;
    logic [7:0]  ov8Red;
    logic [7:0]  ov8Green;
    logic [7:0]  ov8Blue;
    logic        oRgbVd;
    logic        oRgbVs;
    logic        oRgbHs;
    logic [11:0] ov12FrameCnt;
    logic        oOddLine;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Output history indexed by cycle number, sampled on the falling edge.
    logic [23:0] cap_rgb [4096];
    logic        cap_vd  [4096];
    logic        cap_vs  [4096];
    logic        cap_hs  [4096];

    // Stimulus for the next line and the hand-computed RGB for each pixel.
    logic [7:0]  line_c [16];
    logic [7:0]  line_y [16];
    logic [23:0] exp_rgb [16];

    display_hdmi_yuv422_to_rgb dut (
        .iHdmiClk        (iHdmiClk),
        .iArst           (iArst),
        .iHdmiYuvVs      (iHdmiYuvVs),
        .iHdmiYuvHs      (iHdmiYuvHs),
        .iHdmiYuvDe      (iHdmiYuvDe),
        .iv16HdmiYuvData (iv16HdmiYuvData),
        .ov8Red          (ov8Red),
        .ov8Green        (ov8Green),
        .ov8Blue         (ov8Blue),
        .oRgbVd          (oRgbVd),
        .oRgbVs          (oRgbVs),
        .oRgbHs          (oRgbHs),
        .ov12FrameCnt    (ov12FrameCnt),
        .oOddLine        (oOddLine)
    );

    always #5 iHdmiClk = ~iHdmiClk;

    always @(posedge iHdmiClk) cyc <= cyc + 1;

    always @(negedge iHdmiClk) begin
        cap_rgb[cyc % 4096] <= {ov8Red, ov8Green, ov8Blue};
        cap_vd[cyc % 4096]  <= oRgbVd;
        cap_vs[cyc % 4096]  <= oRgbVs;
        cap_hs[cyc % 4096]  <= oRgbHs;
    end

    // Drive line_c/line_y for n pixels, then idle long enough to flush.
    // start is the cycle of the first pixel; pixel i appears at start+5+i.
    task automatic send_line(input int n, output int start);
        start = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge iHdmiClk);
            if (i == 0) start = cyc;
            iHdmiYuvDe      = 1'b1;
            iv16HdmiYuvData = {line_c[i], line_y[i]};
        end
        @(negedge iHdmiClk);
        iHdmiYuvDe      = 1'b0;
        iv16HdmiYuvData = 16'h0;
        repeat (8) @(negedge iHdmiClk);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({ov8Red, ov8Green, ov8Blue, oRgbVd, oRgbVs, oRgbHs} !== 27'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rgb=%h vd=%b vs=%b hs=%b, want all 0",
                     {ov8Red, ov8Green, ov8Blue}, oRgbVd, oRgbVs, oRgbHs);
        end
        n_checks++;
        if (ov12FrameCnt !== 12'd0 || oOddLine !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got frame=%0d odd=%b, want 0/0", ov12FrameCnt, oOddLine);
        end
        $display("reset: outputs sampled while iArst high");
    endtask

    task automatic test_black();
        int s;
        for (int i = 0; i < 8; i++) begin
            line_c[i] = 8'd128;
            line_y[i] = 8'd16;
        end
        send_line(8, s);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cap_vd[(s + 5 + i) % 4096] !== 1'b1 || cap_rgb[(s + 5 + i) % 4096] !== 24'h000000) begin
                n_fail++;
                $display("FAIL black px%0d: got vd=%b rgb=%h, want vd=1 rgb=000000",
                         i, cap_vd[(s + 5 + i) % 4096], cap_rgb[(s + 5 + i) % 4096]);
            end
        end
        n_checks++;
        if (cap_vd[(s + 4) % 4096] !== 1'b0 || cap_vd[(s + 13) % 4096] !== 1'b0) begin
            n_fail++;
            $display("FAIL black_vd_window: got vd before=%b after=%b, want 0/0",
                     cap_vd[(s + 4) % 4096], cap_vd[(s + 13) % 4096]);
        end
        $display("black line: 8 pixels, Vd window checked");
    endtask

    task automatic run_pixel_checks(input string name, input int n, input int s);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (cap_vd[(s + 5 + i) % 4096] !== 1'b1 || cap_rgb[(s + 5 + i) % 4096] !== exp_rgb[i]) begin
                n_fail++;
                $display("FAIL %s px%0d: got vd=%b rgb=%h, want vd=1 rgb=%h",
                         name, i, cap_vd[(s + 5 + i) % 4096], cap_rgb[(s + 5 + i) % 4096], exp_rgb[i]);
            end
        end
        $display("%s line: %0d pixels checked", name, n);
    endtask

    task automatic test_white_gray();
        int s;
        line_c[0] = 8'd128; line_y[0] = 8'd235; exp_rgb[0] = 24'hFFFFFF;
        line_c[1] = 8'd128; line_y[1] = 8'd235; exp_rgb[1] = 24'hFFFFFF;
        line_c[2] = 8'd128; line_y[2] = 8'd126; exp_rgb[2] = 24'h808080;
        line_c[3] = 8'd128; line_y[3] = 8'd126; exp_rgb[3] = 24'h808080;
        send_line(4, s);
        run_pixel_checks("white_gray", 4, s);
    endtask

    task automatic test_saturation();
        int s;
        // y=219, cr=112: R clamps, G=(261048-93184+512)>>10=164, B clamps.
        line_c[0] = 8'd128; line_y[0] = 8'd235; exp_rgb[0] = {8'd255, 8'd164, 8'd255};
        line_c[1] = 8'd240; line_y[1] = 8'd235; exp_rgb[1] = {8'd255, 8'd164, 8'd255};
        send_line(2, s);
        run_pixel_checks("saturation", 2, s);
    endtask

    task automatic test_back_to_back();
        int s;
        // Pair A: y=65 cb=-38 cr=112 -> (254,0,0). Pair B: gray. Pair C: y=110 cb=112 cr=0 -> (128,84,255).
        line_c[0] = 8'd90;  line_y[0] = 8'd81;  exp_rgb[0] = {8'd254, 8'd0, 8'd0};
        line_c[1] = 8'd240; line_y[1] = 8'd81;  exp_rgb[1] = {8'd254, 8'd0, 8'd0};
        line_c[2] = 8'd128; line_y[2] = 8'd126; exp_rgb[2] = 24'h808080;
        line_c[3] = 8'd128; line_y[3] = 8'd126; exp_rgb[3] = 24'h808080;
        line_c[4] = 8'd240; line_y[4] = 8'd126; exp_rgb[4] = {8'd128, 8'd84, 8'd255};
        line_c[5] = 8'd128; line_y[5] = 8'd126; exp_rgb[5] = {8'd128, 8'd84, 8'd255};
        send_line(6, s);
        run_pixel_checks("pairing", 6, s);
    endtask

    task automatic test_odd_line();
        int s;
        n_checks++;
        if (oOddLine !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_flag_before: got %b, want 0", oOddLine);
        end
        // Last pixel: y=65 cb=-38 cr=0 -> (76,91,0).
        line_c[0] = 8'd128; line_y[0] = 8'd126; exp_rgb[0] = 24'h808080;
        line_c[1] = 8'd128; line_y[1] = 8'd126; exp_rgb[1] = 24'h808080;
        line_c[2] = 8'd90;  line_y[2] = 8'd81;  exp_rgb[2] = {8'd76, 8'd91, 8'd0};
        send_line(3, s);
        run_pixel_checks("odd_line", 3, s);
        n_checks++;
        if (oOddLine !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_flag_after: got %b, want 1", oOddLine);
        end
    endtask

    task automatic test_sync();
        int s;
        for (int p = 0; p < 2; p++) begin
            @(negedge iHdmiClk);
            s = cyc;
            iHdmiYuvVs = 1'b0;
            iHdmiYuvHs = 1'b0;
            @(negedge iHdmiClk);
            iHdmiYuvVs = 1'b1;
            iHdmiYuvHs = 1'b1;
            repeat (8) @(negedge iHdmiClk);
            n_checks++;
            if (cap_vs[(s + 4) % 4096] !== 1'b0 || cap_vs[(s + 5) % 4096] !== 1'b1 ||
                cap_vs[(s + 6) % 4096] !== 1'b0) begin
                n_fail++;
                $display("FAIL vs_latency pulse%0d: got t+4..6=%b%b%b, want 010", p,
                         cap_vs[(s + 4) % 4096], cap_vs[(s + 5) % 4096], cap_vs[(s + 6) % 4096]);
            end
            n_checks++;
            if (cap_hs[(s + 4) % 4096] !== 1'b0 || cap_hs[(s + 5) % 4096] !== 1'b1 ||
                cap_hs[(s + 6) % 4096] !== 1'b0) begin
                n_fail++;
                $display("FAIL hs_latency pulse%0d: got t+4..6=%b%b%b, want 010", p,
                         cap_hs[(s + 4) % 4096], cap_hs[(s + 5) % 4096], cap_hs[(s + 6) % 4096]);
            end
            n_checks++;
            if (ov12FrameCnt !== 12'(p + 1)) begin
                n_fail++;
                $display("FAIL frame_cnt pulse%0d: got %0d, want %0d", p, ov12FrameCnt, p + 1);
            end
            $display("sync pulse %0d: Vs/Hs latency and frame count checked", p);
        end
    endtask

    task automatic test_frame_wrap();
        for (int p = 0; p < 4093; p++) begin
            @(negedge iHdmiClk);
            iHdmiYuvVs = 1'b0;
            @(negedge iHdmiClk);
            iHdmiYuvVs = 1'b1;
        end
        @(negedge iHdmiClk);
        n_checks++;
        if (ov12FrameCnt !== 12'd4095) begin
            n_fail++;
            $display("FAIL frame_cnt_max: got %0d, want 4095", ov12FrameCnt);
        end
        @(negedge iHdmiClk);
        iHdmiYuvVs = 1'b0;
        @(negedge iHdmiClk);
        iHdmiYuvVs = 1'b1;
        @(negedge iHdmiClk);
        n_checks++;
        if (ov12FrameCnt !== 12'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_wrap: got %0d, want 0", ov12FrameCnt);
        end
        $display("frame counter: 4095 -> 0 wrap checked");
    endtask

    task automatic test_sticky();
        int s;
        for (int i = 0; i < 4; i++) begin
            line_c[i] = 8'd128;
            line_y[i] = 8'd126;
            exp_rgb[i] = 24'h808080;
        end
        send_line(4, s);
        run_pixel_checks("even_after_odd", 4, s);
        n_checks++;
        if (oOddLine !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_flag_sticky: got %b, want 1", oOddLine);
        end
    endtask

    task automatic test_midline_reset();
        int s;
        // Five white pixels in flight, reset lands between clock edges.
        for (int i = 0; i < 8; i++) begin
            @(negedge iHdmiClk);
            iHdmiYuvDe      = 1'b1;
            iv16HdmiYuvData = {8'd128, 8'd235};
        end
        #1;
        iArst = 1'b1;
        #1;
        n_checks++;
        if ({ov8Red, ov8Green, ov8Blue, oRgbVd, oRgbVs, oRgbHs} !== 27'h0) begin
            n_fail++;
            $display("FAIL midline_reset_outputs: got rgb=%h vd=%b vs=%b hs=%b, want all 0",
                     {ov8Red, ov8Green, ov8Blue}, oRgbVd, oRgbVs, oRgbHs);
        end
        n_checks++;
        if (ov12FrameCnt !== 12'd0 || oOddLine !== 1'b0) begin
            n_fail++;
            $display("FAIL midline_reset_status: got frame=%0d odd=%b, want 0/0", ov12FrameCnt, oOddLine);
        end
        iHdmiYuvDe      = 1'b0;
        iv16HdmiYuvData = 16'h0;
        repeat (2) @(negedge iHdmiClk);
        iArst = 1'b0;
        repeat (2) @(negedge iHdmiClk);
        $display("mid-line reset: outputs cleared asynchronously");
        // First line after reset must pair from an even pixel.
        line_c[0] = 8'd90;  line_y[0] = 8'd81; exp_rgb[0] = {8'd254, 8'd0, 8'd0};
        line_c[1] = 8'd240; line_y[1] = 8'd81; exp_rgb[1] = {8'd254, 8'd0, 8'd0};
        send_line(2, s);
        run_pixel_checks("after_reset", 2, s);
    endtask

    initial begin
        repeat (3) @(negedge iHdmiClk);
        test_reset();
        iArst = 1'b0;
        repeat (2) @(negedge iHdmiClk);
        test_black();
        test_white_gray();
        test_saturation();
        test_back_to_back();
        test_odd_line();
        test_sync();
        test_frame_wrap();
        test_sticky();
        test_midline_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
